gmii_tx_arbiter: RTL and testbench
==================================

Name: gmii_tx_arbiter

Overview:
- Shares the single GMII transmit port of the RGMII bridge between N_REQ byte-stream requesters, e.g. ARP responder, UDP TX and the CPU MMIO TX FIFO.
- Per frame: selects one requester round-robin, emits preamble and SFD, streams the payload, zero-pads to the Ethernet minimum, then enforces the inter-frame gap.
- Runs entirely in the gmii_txc domain. Its outputs drive gmii_txen/gmii_txd of the bridge directly.
- FCS is supplied by the requester as part of its payload.

Parameters:
- N_REQ, 2, number of requesters (1..8).
- MIN_FRAME, 60, minimum payload byte count (DA through end of payload, excluding FCS) before padding stops.
- IFG_BYTES, 12, idle cycles with txen=0 after every frame.
- PREAMBLE_LEN, 7, count of 0x55 bytes before SFD.

Ports:
- gmii_txc  in  1  transmit clock, 125 MHz.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  requester i has a byte on req_data[i].
- req_data  in  N_REQ*8  byte lanes, lane i = bits [8i+7:8i].
- req_last  in  N_REQ  byte on lane i is the final byte of its frame.
- req_ready  out  N_REQ  byte accepted on lane i this cycle (valid & ready).
- gmii_txen  out  1  GMII transmit enable.
- gmii_txd  out  8  GMII transmit data.
- grant_id  out  $clog2(N_REQ) (min 1)  index of the current or most recent owner.
- busy  out  1  state != IDLE.
- underrun  out  1  one-cycle pulse: owner dropped valid mid-frame.

Behaviour:
- Reset: state=IDLE, gmii_txen=0, gmii_txd=0x00, req_ready=0, grant_id=0, underrun=0. The round-robin pointer resets so requester 0 has highest priority.
- gmii_txen, gmii_txd and underrun are registered. req_ready is combinational from state and grant only, never from req_valid.
- FSM states: IDLE, PRE, SFD, DATA, PAD, IFG.
- IDLE: if any req_valid, grant the first requester at or after (last_grant+1) mod N_REQ, register grant_id, go to PRE. Arbitration happens only in IDLE; a grant is held until that frame's IFG ends.
- PRE: gmii_txen=1, gmii_txd=0x55 for PREAMBLE_LEN cycles, then SFD.
- SFD: gmii_txd=0xD5 for one cycle. req_ready[grant] is asserted during this cycle so the first payload byte appears on gmii_txd the cycle after 0xD5, with no gap.
- DATA:
  - req_ready[grant]=1 until the accepted byte has req_last.
  - Each accepted byte is driven on gmii_txd the next cycle, and the 16-bit byte_cnt increments.
  - On accepted last: go to PAD if byte_cnt+1 < MIN_FRAME, else go to IFG.
  - If req_valid[grant]=0 while ready: underrun pulses next cycle, txen drops, go to IFG. The frame is truncated and the requester must restart.
- PAD: gmii_txen=1, gmii_txd=0x00 until byte_cnt reaches MIN_FRAME, then IFG.
- IFG: gmii_txen=0, gmii_txd=0x00 for exactly IFG_BYTES cycles, then IDLE. An IDLE cycle with pending valid arbitrates in that same cycle.
- Frame-start latency: valid seen in IDLE at cycle T gives the first 0x55 at T+1, 0xD5 at T+8 and payload byte 0 at T+9.
- Non-granted requesters always see ready=0. Other requesters' valid/data/last toggling has no effect.
- byte_cnt saturates at 0xFFFF. Oversized frames are not truncated.
- A one-byte frame (last on first byte) gives 1 data byte plus 59 pad bytes.
- rst asserted mid-frame: everything returns to reset values on the next edge, txen=0 immediately after, no IFG enforced.

Decomposition:
- Package gmii_tx_pkg holds: the state enum tx_state_e, constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, PAD_BYTE=8'h00, and the defaults for MIN_FRAME and IFG_BYTES.
- One sub-module, rr_arbiter (N_REQ, req vector, advance strobe → one-hot grant plus index, rotating pointer), kept reusable for the MMIO bus.

Test Plan:
- Single 64-byte frame from req0 (bytes 0x00..0x3F), valid held → txen high for 72 cycles: 7×0x55, 0xD5, 0x00..0x3F. Then 12 cycles txen=0, no PAD.
- 10-byte frame from req1 → 10 data bytes, then 50×0x00 pad, txen high for 68 cycles total, grant_id=1, then 12 IFG cycles.
- req0 and req1 both valid continuously, 60-byte frames each → grants alternate 0,1,0,1. The gap between frames is exactly 12 txen=0 cycles plus 1 IDLE cycle.
- req0 drops valid after 20 accepted bytes → underrun=1 for one cycle, txen falls after byte 20, IFG of 12, then req1 can be granted.
- 1-byte frame (data 0xAB, last=1) → 0xAB followed by 59×0x00, underrun never asserted.
- rst pulsed at payload byte 30 → next cycle txen=0, ready=0, grant_id=0. A new frame from req1 afterwards starts cleanly with 7×0x55.

Source files
------------

// File: rtl/gmii_tx_pkg.sv
// Shared types and constants for the GMII transmit arbiter.
// Holds the frame FSM state encoding, the fixed framing bytes and the default sizes.
package gmii_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      SFD,
      DATA,
      PAD,
      IFG
   } tx_state_e;

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;
   localparam logic [7:0] PAD_BYTE      = 8'h00;

   localparam int MIN_FRAME_DEFAULT    = 60;
   localparam int IFG_BYTES_DEFAULT    = 12;
   localparam int PREAMBLE_LEN_DEFAULT = 7;

   // Byte counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant plus index, pointer rotates on advance.
// After reset requester 0 has the highest priority.
module rr_arbiter #(
   parameter int N_REQ = 2,
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             advance,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any_req
);

   logic [IDX_W-1:0] last_ptr;

   // Scan starting just after the previous winner, wrapping once.
   always_comb begin
      int   cand;
      logic found;
      cand      = 0;
      found     = 1'b0;
      grant     = '0;
      grant_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = int'(last_ptr) + 1 + i;
         if (cand >= N_REQ) cand = cand - N_REQ;
         for (int j = 0; j < N_REQ; j++) begin
            if (!found && (j == cand) && req[j]) begin
               found     = 1'b1;
               grant[j]  = 1'b1;
               grant_idx = IDX_W'(j);
            end
         end
      end
   end

   assign any_req = |req;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_ptr <= IDX_W'(N_REQ - 1);
      end else if (advance && any_req) begin
         last_ptr <= grant_idx;
      end
   end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Shares one GMII transmit port among N_REQ byte-stream requesters, adding
// preamble/SFD, padding short frames to the minimum and enforcing the inter-frame gap.
module gmii_tx_arbiter
   import gmii_tx_pkg::*;
#(
   parameter int N_REQ        = 2,
   parameter int MIN_FRAME    = MIN_FRAME_DEFAULT,
   parameter int IFG_BYTES    = IFG_BYTES_DEFAULT,
   parameter int PREAMBLE_LEN = PREAMBLE_LEN_DEFAULT,
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic               gmii_txc,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*8-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic               gmii_txen,
   output logic [7:0]         gmii_txd,
   output logic [IDX_W-1:0]   grant_id,
   output logic               busy,
   output logic               underrun
);

   tx_state_e        state, state_next;
   logic [15:0]      phase_cnt, phase_next;
   logic [15:0]      byte_cnt, byte_next;
   logic             data_done, done_next;
   logic             txen_next, underrun_next;
   logic [7:0]       txd_next;
   logic [N_REQ-1:0] grant_oh;
   logic [N_REQ-1:0] arb_grant;
   logic [IDX_W-1:0] arb_idx;
   logic             arb_any;
   logic             advance;
   logic             accepting;
   logic             lane_valid, lane_last;
   logic [7:0]       lane_data;

   rr_arbiter #(
      .N_REQ(N_REQ)
   ) u_arb (
      .clk      (gmii_txc),
      .rst      (rst),
      .req      (req_valid),
      .advance  (advance),
      .grant    (arb_grant),
      .grant_idx(arb_idx),
      .any_req  (arb_any)
   );

   // The owner's lane is picked from the registered grant so it stays fixed for the frame.
   always_comb begin
      lane_valid = 1'b0;
      lane_last  = 1'b0;
      lane_data  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_id == IDX_W'(i)) begin
            lane_valid = req_valid[i];
            lane_last  = req_last[i];
            lane_data  = req_data[i*8 +: 8];
         end
      end
   end

   assign advance   = (state == IDLE) && arb_any;
   assign accepting = (state == SFD) || ((state == DATA) && !data_done);
   assign req_ready = accepting ? grant_oh : '0;
   assign busy      = (state != IDLE);

   // Next-state logic also decides what appears on the wire next cycle, so the
   // registered outputs line up with the state that produced them.
   always_comb begin
      state_next    = state;
      phase_next    = phase_cnt;
      byte_next     = byte_cnt;
      done_next     = data_done;
      txen_next     = 1'b0;
      txd_next      = PAD_BYTE;
      underrun_next = 1'b0;
      case (state)
         IDLE: begin
            if (arb_any) begin
               state_next = PRE;
               phase_next = '0;
               byte_next  = '0;
               done_next  = 1'b0;
               txen_next  = 1'b1;
               txd_next   = PREAMBLE_BYTE;
            end
         end
         PRE: begin
            txen_next = 1'b1;
            if (phase_cnt >= 16'(PREAMBLE_LEN - 1)) begin
               state_next = SFD;
               txd_next   = SFD_BYTE;
            end else begin
               phase_next = phase_cnt + 16'd1;
               txd_next   = PREAMBLE_BYTE;
            end
         end
         SFD, DATA: begin
            if ((state == DATA) && data_done) begin
               if (byte_cnt < 16'(MIN_FRAME)) begin
                  state_next = PAD;
                  txen_next  = 1'b1;
                  byte_next  = sat_inc16(byte_cnt);
               end else begin
                  state_next = IFG;
                  phase_next = '0;
               end
            end else if (lane_valid) begin
               state_next = DATA;
               txen_next  = 1'b1;
               txd_next   = lane_data;
               byte_next  = sat_inc16(byte_cnt);
               done_next  = lane_last;
            end else begin
               // Owner starved us mid-frame: cut the frame short and flag it.
               state_next    = IFG;
               phase_next    = '0;
               underrun_next = 1'b1;
            end
         end
         PAD: begin
            if (byte_cnt < 16'(MIN_FRAME)) begin
               txen_next = 1'b1;
               byte_next = sat_inc16(byte_cnt);
            end else begin
               state_next = IFG;
               phase_next = '0;
            end
         end
         IFG: begin
            if (phase_cnt >= 16'(IFG_BYTES - 1)) begin
               state_next = IDLE;
            end else begin
               phase_next = phase_cnt + 16'd1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge gmii_txc) begin
      if (rst) begin
         state     <= IDLE;
         phase_cnt <= '0;
         byte_cnt  <= '0;
         data_done <= 1'b0;
         grant_id  <= '0;
         grant_oh  <= '0;
         gmii_txen <= 1'b0;
         gmii_txd  <= 8'h00;
         underrun  <= 1'b0;
      end else begin
         state     <= state_next;
         phase_cnt <= phase_next;
         byte_cnt  <= byte_next;
         data_done <= done_next;
         gmii_txen <= txen_next;
         gmii_txd  <= txd_next;
         underrun  <= underrun_next;
         if (advance) begin
            grant_id <= arb_idx;
            grant_oh <= arb_grant;
         end
      end
   end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Scoreboard bench for gmii_tx_arbiter: stimulus queues expected wire bytes,
// a negedge monitor pops and compares them whenever gmii_txen is high.
module tb_gmii_tx_arbiter;

   localparam int N_REQ     = 2;
   localparam int MIN_FRAME = 60;
   localparam int IFG_BYTES = 12;

   logic        gmii_txc = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [15:0] req_data;
   logic [1:0]  req_last;
   logic [1:0]  req_ready;
   logic        gmii_txen;
   logic [7:0]  gmii_txd;
   logic [0:0]  grant_id;
   logic        busy;
   logic        underrun;

   gmii_tx_arbiter #(
      .N_REQ       (N_REQ),
      .MIN_FRAME   (MIN_FRAME),
      .IFG_BYTES   (IFG_BYTES),
      .PREAMBLE_LEN(7)
   ) dut (
      .gmii_txc (gmii_txc),
      .rst      (rst),
      .req_valid(req_valid),
      .req_data (req_data),
      .req_last (req_last),
      .req_ready(req_ready),
      .gmii_txen(gmii_txen),
      .gmii_txd (gmii_txd),
      .grant_id (grant_id),
      .busy     (busy),
      .underrun (underrun)
   );

   always #4 gmii_txc = ~gmii_txc;

   typedef struct packed {
      logic [7:0] d;
      logic       g;
   } exp_t;

   exp_t exp_bytes[$];
   int   exp_len[$];
   int   exp_gap[$];
   int   checks  = 0;
   int   errors  = 0;
   int   ur_seen = 0;
   bit   mon_en  = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic abortRun(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   // Queue the bytes a frame should put on the wire; shown < n means it gets cut short.
   task automatic pushFrame(input logic gid, input int n, input logic [7:0] base, input int shown, input int gap);
      exp_t e;
      int   total;
      e.g = gid;
      for (int i = 0; i < 7; i++) begin
         e.d = 8'h55;
         exp_bytes.push_back(e);
      end
      e.d = 8'hD5;
      exp_bytes.push_back(e);
      for (int i = 0; i < shown; i++) begin
         e.d = base + 8'(i);
         exp_bytes.push_back(e);
      end
      total = 8 + shown;
      if ((shown == n) && (n < MIN_FRAME)) begin
         for (int i = 0; i < MIN_FRAME - n; i++) begin
            e.d = 8'h00;
            exp_bytes.push_back(e);
         end
         total = total + MIN_FRAME - n;
      end
      exp_len.push_back(total);
      exp_gap.push_back(gap);
   endtask

   task automatic setLane(input logic lane, input logic v, input logic [7:0] d, input logic l);
      req_valid[lane]                = v;
      req_data[{lane, 3'b000} +: 8] = d;
      req_last[lane]                 = l;
   endtask

   // Streams base, base+1, ... on one lane; at byte index 'stop' it drops valid
   // (and optionally raises rst) and returns. Called and returns on a negedge.
   task automatic applyStimulus(input logic lane, input int n, input logic [7:0] base, input int stop, input bit do_reset);
      for (int i = 0; i < n; i++) begin
         int t;
         t = 0;
         if (i == stop) begin
            setLane(lane, 1'b0, 8'h00, 1'b0);
            if (do_reset) rst = 1'b1;
            return;
         end
         setLane(lane, 1'b1, base + 8'(i), (i == n - 1));
         while (!req_ready[lane]) begin
            @(negedge gmii_txc);
            t++;
            if (t > 3000) abortRun("ready_timeout");
         end
         @(negedge gmii_txc);
      end
   endtask

   task automatic waitIdle(input bit check_ifg);
      int ifg;
      int t;
      ifg = 0;
      t   = 0;
      while (busy) begin
         if (!gmii_txen) ifg++;
         @(negedge gmii_txc);
         t++;
         if (t > 3000) abortRun("idle_timeout");
      end
      if (check_ifg) checkOutput("ifg_cycles", ifg, IFG_BYTES);
   endtask

   int   zero_run   = 0;
   int   frame_len  = 0;
   int   gap_exp;
   logic prev_txen  = 1'b0;
   logic prev_ur    = 1'b0;
   exp_t mon_e;

   // Monitor: every txen-high sample consumes one expected byte; frame edges check length and gap.
   always @(negedge gmii_txc) begin
      if (mon_en) begin
         if (gmii_txen) begin
            if (!prev_txen) begin
               frame_len = 0;
               if (exp_gap.size() > 0) begin
                  gap_exp = exp_gap.pop_front();
                  if (gap_exp >= 0) checkOutput("gap_before_frame", zero_run, gap_exp);
               end
            end
            frame_len++;
            if (exp_bytes.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_byte: got 0x%0h expected no transmission at %0t", gmii_txd, $time);
            end else begin
               mon_e = exp_bytes.pop_front();
               checkOutput("txd", gmii_txd, mon_e.d);
               checkOutput("grant_id", grant_id, mon_e.g);
            end
         end else begin
            if (prev_txen) begin
               if (exp_len.size() > 0) begin
                  checkOutput("frame_len", frame_len, exp_len.pop_front());
               end else begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_frame: got length %0d expected none at %0t", frame_len, $time);
               end
               zero_run = 0;
            end
            zero_run++;
         end
         if (underrun) begin
            ur_seen++;
            checkOutput("underrun_txen", gmii_txen, 0);
            checkOutput("underrun_width", prev_ur, 0);
         end
         prev_txen = gmii_txen;
         prev_ur   = underrun;
      end
   end

   initial begin
      #1_000_000;
      abortRun("global_timeout");
   end

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      repeat (3) @(negedge gmii_txc);
      $display("[TB] reset state");
      checkOutput("rst_txen", gmii_txen, 0);
      checkOutput("rst_txd", gmii_txd, 0);
      checkOutput("rst_ready", req_ready, 0);
      checkOutput("rst_grant", grant_id, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_underrun", underrun, 0);
      rst    = 1'b0;
      mon_en = 1'b1;

      $display("[TB] 64-byte frame from req0");
      pushFrame(1'b0, 64, 8'h00, 64, -1);
      applyStimulus(1'b0, 64, 8'h00, -1, 1'b0);
      setLane(1'b0, 1'b0, 8'h00, 1'b0);
      waitIdle(1'b1);

      $display("[TB] 10-byte frame from req1 with padding");
      pushFrame(1'b1, 10, 8'h10, 10, -1);
      applyStimulus(1'b1, 10, 8'h10, -1, 1'b0);
      setLane(1'b1, 1'b0, 8'h00, 1'b0);
      waitIdle(1'b1);

      $display("[TB] both requesters continuously valid");
      pushFrame(1'b0, 60, 8'h40, 60, -1);
      pushFrame(1'b1, 60, 8'hC0, 60, IFG_BYTES + 1);
      pushFrame(1'b0, 60, 8'h80, 60, IFG_BYTES + 1);
      pushFrame(1'b1, 60, 8'h20, 60, IFG_BYTES + 1);
      fork
         begin
            applyStimulus(1'b0, 60, 8'h40, -1, 1'b0);
            applyStimulus(1'b0, 60, 8'h80, -1, 1'b0);
            setLane(1'b0, 1'b0, 8'h00, 1'b0);
         end
         begin
            applyStimulus(1'b1, 60, 8'hC0, -1, 1'b0);
            applyStimulus(1'b1, 60, 8'h20, -1, 1'b0);
            setLane(1'b1, 1'b0, 8'h00, 1'b0);
         end
      join
      waitIdle(1'b1);

      $display("[TB] req0 starves after 20 bytes");
      pushFrame(1'b0, 40, 8'h60, 20, -1);
      applyStimulus(1'b0, 40, 8'h60, 20, 1'b0);
      waitIdle(1'b1);
      checkOutput("underrun_count", ur_seen, 1);

      $display("[TB] one-byte frame from req1");
      pushFrame(1'b1, 1, 8'hAB, 1, -1);
      applyStimulus(1'b1, 1, 8'hAB, -1, 1'b0);
      setLane(1'b1, 1'b0, 8'h00, 1'b0);
      waitIdle(1'b1);
      checkOutput("underrun_after_short", ur_seen, 1);

      $display("[TB] reset during payload byte 30");
      pushFrame(1'b1, 64, 8'h00, 30, -1);
      applyStimulus(1'b1, 64, 8'h00, 30, 1'b0 | 1'b1);
      @(negedge gmii_txc);
      checkOutput("midrst_txen", gmii_txen, 0);
      checkOutput("midrst_ready", req_ready, 0);
      checkOutput("midrst_grant", grant_id, 0);
      checkOutput("midrst_busy", busy, 0);
      rst = 1'b0;
      pushFrame(1'b1, 10, 8'hE0, 10, -1);
      applyStimulus(1'b1, 10, 8'hE0, -1, 1'b0);
      setLane(1'b1, 1'b0, 8'h00, 1'b0);
      waitIdle(1'b1);

      repeat (2) @(negedge gmii_txc);
      checkOutput("bytes_left", exp_bytes.size(), 0);
      checkOutput("frames_left", exp_len.size(), 0);
      checkOutput("underrun_final", ur_seen, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
